// File: rtl/div32u_pkg.sv
// Shared definitions for the sequential unsigned divider.
// Contents: FSM state encoding, operand width, step count, step counter width.
package div32u_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div32u_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem_in   [W:0]   current partial remainder
//   quo_in   [W-1:0] current quotient/shift register
//   divisor  [W-1:0] divisor
//   rem_out  [W:0]   next partial remainder
//   quo_out  [W-1:0] next quotient/shift register (new quotient bit in LSB)
module div_step
    import div32u_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W:0]   rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_out,
    output logic [W-1:0] quo_out
);

    logic [W:0]   shifted;
    logic [W+1:0] trial;

    always_comb begin
        shifted = {rem_in[W-1:0], quo_in[W-1]};
        // One extra bit on top so the borrow is visible even for the
        // full 33-bit shifted remainder.
        trial   = {rem_in[W], shifted} - {2'b00, divisor};
        if (trial[W+1]) begin
            rem_out = shifted;
            quo_out = {quo_in[W-2:0], 1'b0};
        end else begin
            rem_out = trial[W:0];
            quo_out = {quo_in[W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div32u.sv
// Sequential unsigned divider, restoring algorithm, one quotient bit per
// clock, fixed 32-cycle latency from acceptance to out_valid.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  operand handshake (in_ready only in IDLE)
//   op1, op2           dividend, divisor (sampled in the accept cycle only)
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   quo, rem, dbz      quotient, remainder, divide-by-zero flag
//
// State table:
//   IDLE | waiting for operands, in_ready high
//   CALC | one restoring step per cycle, 32 steps
//   DONE | result presented, out_valid high until out_ready
module div32u
    import div32u_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem,
    output logic         dbz
);

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [W:0]       rem_q, rem_step;
    logic [W-1:0]     quo_q, quo_step, divisor_q;
    logic             dbz_q;

    div_step #(.W(W)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        divisor_q <= op2;
                        quo_q     <= op1;
                        rem_q     <= '0;
                        cnt       <= '0;
                        dbz_q     <= (op2 == '0);
                    end
                end
                CALC: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: begin
                if (cnt == CNT_W'(DIV_STEPS - 1)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results stay in the working registers; they are only overwritten
    // by the next acceptance, so they hold after the output handshake.
    assign quo = quo_q;
    assign rem = rem_q[W-1:0];
    assign dbz = dbz_q;

endmodule

// File: tb/tb_div32u.sv
module tb_div32u;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dbz;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[10];

    div32u dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quo       (quo),
        .rem       (rem),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at a negedge right after the accept edge; returns the number of
    // rising edges after acceptance until out_valid is seen.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 100);
    endtask

    // Called at a negedge with the divider in IDLE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r,
                          input logic z, input string name);
        int n;
        chk({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
        op1 = a;
        op2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op1 = 32'hDEAD_BEEF;
        op2 = 32'h0;
        wait_done(n);
        chk({name, " latency"}, n, 32);
        chk({name, " quo"}, quo, q);
        chk({name, " rem"}, rem, r);
        chk({name, " dbz"}, {31'b0, dbz}, {31'b0, z});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " idle in_ready"}, {31'b0, in_ready}, 32'd1);
        chk({name, " idle out_valid"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] a, b, eq, er;
        logic ez;
        time t_acc, t_prev;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[2] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        vecs[3] = '{32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
        vecs[6] = '{32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0,          1'b0};
        vecs[7] = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0};
        vecs[8] = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};
        vecs[9] = '{32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  32'd5,          1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op1 = '0;
        op2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset quo", quo, 32'd0);
        chk("reset rem", rem, 32'd0);
        chk("reset dbz", {31'b0, dbz}, 32'd0);

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, $sformatf("vec%0d", i));

        // Backpressure: 50 / 6 = 8 r 2, held in DONE for 5 cycles.
        op1 = 32'd50;
        op2 = 32'd6;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(n);
        chk("bp latency", n, 32);
        for (int k = 0; k < 5; k++) begin
            chk("bp out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp quo", quo, 32'd8);
            chk("bp rem", rem, 32'd2);
            chk("bp in_ready", {31'b0, in_ready}, 32'd0);
            in_valid = (k == 2);
            op1 = 32'd77;
            op2 = 32'd1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp release out_valid", {31'b0, out_valid}, 32'd0);
        chk("bp hold quo", quo, 32'd8);
        chk("bp hold rem", rem, 32'd2);
        @(posedge clk);
        @(negedge clk);
        chk("bp still idle", {31'b0, in_ready}, 32'd1);

        // Reset at step 10 of 1000 / 3.
        op1 = 32'd1000;
        op2 = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid rst quo", quo, 32'd0);
        chk("mid rst rem", rem, 32'd0);
        chk("mid rst dbz", {31'b0, dbz}, 32'd0);
        run_op(32'd9, 32'd4, 32'd2, 32'd1, 1'b0, "after rst");

        // Back-to-back, out_ready tied high, in_valid held high.
        out_ready = 1'b1;
        in_valid = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom_range(0, 15);
                1: b = $urandom;
                2: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom_range(1, 1000);
            endcase
            if (b == 0) begin
                eq = 32'hFFFF_FFFF;
                er = a;
                ez = 1'b1;
            end else begin
                eq = a / b;
                er = a % b;
                ez = 1'b0;
            end
            chk("b2b in_ready", {31'b0, in_ready}, 32'd1);
            op1 = a;
            op2 = b;
            @(posedge clk);
            t_acc = $time;
            if (i > 0) chk("b2b interval", 32'((t_acc - t_prev) / 10), 32'd34);
            t_prev = t_acc;
            @(negedge clk);
            op1 = ~a;
            op2 = ~b;
            wait_done(n);
            chk("b2b latency", n, 32);
            chk("b2b quo", quo, eq);
            chk("b2b rem", rem, er);
            chk("b2b dbz", {31'b0, dbz}, {31'b0, ez});
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div32u.md
# div32u

Sequential unsigned 32-bit divider: the inverse of the combinational 32×32 unsigned multiplier in the arithmetic library. It computes quotient and remainder of `op1 / op2` by restoring division, one quotient bit per clock. It uses a valid/ready handshake on both sides and has a fixed latency, independent of the data. It sits beside the multiplier in the execute-stage arithmetic unit and serves DIVU/REMU-style operations.

## Interface
- `W`, default 32: operand width. Only 32 is verified.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands present on `op1`/`op2`.
- `in_ready`  out  1  divider can accept operands; high only in IDLE.
- `op1`  in  32  dividend, unsigned.
- `op2`  in  32  divisor, unsigned.
- `out_valid`  out  1  `quo`/`rem`/`dbz` are valid; high only in DONE.
- `out_ready`  in  1  consumer takes the result.
- `quo`  out  32  quotient.
- `rem`  out  32  remainder.
- `dbz`  out  1  divisor was zero for this result.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `op2` into the divisor register and `op1` into the quotient/shift register.
  - Clear the 33-bit partial remainder, set step counter=0, set `dbz` = (`op2`==0), go to CALC.
- CALC, one step per cycle:
  - Shift {partial remainder, quotient reg} left by 1.
  - Trial value = shifted remainder − {1'b0, divisor}, 33-bit.
  - If no borrow, the remainder takes the trial value and quotient LSB = 1. Otherwise the remainder keeps the shifted value and quotient LSB = 0.
  - After step 31 (counter==31), go to DONE.
- DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- Divide by zero is not special-cased. The algorithm naturally yields `quo`=32'hFFFF_FFFF and `rem`=`op1`, and `dbz`=1.
- `quo`/`rem`/`dbz` hold their values after the output handshake until the next acceptance.
- `in_valid` is ignored outside IDLE. Operands need only be stable in the accept cycle.
- Reset, including mid-CALC or in DONE:
  - State goes to IDLE and the counter to 0.
  - `in_ready`=1, `out_valid`=0, `quo`=0, `rem`=0, `dbz`=0.
  - The in-flight operation is discarded silently.

## Timing
- Accept edge E0 (`in_valid`&`in_ready`). The steps occur on edges E1..E32. DONE is entered at E32, so `out_valid` is high in the cycle after E32. Latency is exactly 32 cycles from acceptance to `out_valid`, for all operands.
- `in_ready` drops in the cycle after E0 and returns in the cycle after the output handshake edge.
- Peak throughput is one division per 34 cycles: accept, 32 steps, 1 DONE cycle with `out_ready` already high.
- `out_valid` stays high indefinitely while `out_ready`=0, and the outputs stay stable.
- A new operation is never accepted in the same cycle as the output handshake.
- `rst` has priority over every other event in the same cycle.

## Structure
- Shared arithmetic package:
  - state enum {IDLE, CALC, DONE}.
  - `DIV_W`=32.
  - `DIV_STEPS`=32.
  - Counter width = 5 bits.
- Sub-module `div_step`: purely combinational, one restoring iteration. Inputs are the 33-bit remainder, the 32-bit quotient reg and the 32-bit divisor. Outputs are the next remainder and next quotient. It is unit-testable in isolation.
- The top level holds the FSM, the counter, the operand/result registers and the handshake.

## Test plan
- 100 / 7 -> `quo`=14, `rem`=2, `dbz`=0; `out_valid` rises exactly 32 cycles after acceptance.
- 32'hFFFF_FFFF / 1 -> `quo`=32'hFFFF_FFFF, `rem`=0; 3 / 10 -> `quo`=0, `rem`=3.
- 32'h1234_5678 / 0 -> `quo`=32'hFFFF_FFFF, `rem`=32'h1234_5678, `dbz`=1, with the same 32-cycle latency.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in DONE. `out_valid` and the outputs stay stable, `in_ready`=0, and a pulsed `in_valid` is ignored.
  - Then raise `out_ready`. The state returns to IDLE next cycle.
- Assert `rst` for 1 cycle at step 10 of 1000 / 3. Next cycle: `in_ready`=1, `out_valid`=0, `quo`=`rem`=0. Then 9 / 4 -> `quo`=2, `rem`=1.
- Back-to-back with `out_ready` tied high, 200 random operand pairs:
  - Each result matches `op1/op2` and `op1%op2`. Division by zero uses the rule above.
  - Throughput is exactly 34 cycles per operation.
